// File: rtl/fir_coef_loader_pkg.sv
// rtl/fir_coef_loader_pkg.sv - shared types and defaults for the FIR coefficient loader
//
// Purpose: loader FSM state encoding and the default coefficient width and tap count
//          used by the filter top.
// Ports:   none (package)

package fir_coef_loader_pkg;

  localparam int DEF_WIDTH_B = 18;
  localparam int DEF_NTAPS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow and active coefficient registers with atomic swap
//
// Purpose: holds the NTAPS x WIDTH_B shadow bank written one word at a time and the
//          active bank that feeds the tap chain. A swap copies the whole shadow bank
//          into the active bank in one cycle.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, clears both banks
//   wr_en    write wr_data into shadow tap wr_idx
//   wr_idx   shadow tap index
//   wr_data  coefficient word
//   swap     copy shadow into active
//   b_out    active bank, tap k at [k*WIDTH_B +: WIDTH_B]

module fir_coef_bank
  import fir_coef_loader_pkg::*;
#(
  parameter int WIDTH_B = DEF_WIDTH_B,
  parameter int NTAPS   = DEF_NTAPS,
  localparam int IDX_W  = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [WIDTH_B-1:0]       wr_data,
  input  logic                     swap,
  output logic [NTAPS*WIDTH_B-1:0] b_out
);

  logic [NTAPS*WIDTH_B-1:0] shadow_q;
  logic [NTAPS*WIDTH_B-1:0] shadow_d;
  logic [NTAPS*WIDTH_B-1:0] active_q;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          shadow_d[k*WIDTH_B +: WIDTH_B] = wr_data;
        end
      end
    end
  end

  // Reset wins over swap so an ARMED bank cannot leak into b_out on the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (swap) begin
        active_q <= shadow_q;
      end
    end
  end

  assign b_out = active_q;

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - serial coefficient loader with atomic bank swap on ena
//
// Purpose: accepts a coefficient set over valid/ready, assembles it in the shadow bank
//          and swaps it into the active bank on the first sample-advance cycle after a
//          complete set, so one output sample never sees mixed coefficients.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   ena       sample-advance enable shared with the tap chain
//   s_valid   coefficient word valid
//   s_ready   loader can accept a word (0 in ARMED and during reset)
//   s_data    coefficient, two's complement, stored verbatim
//   s_last    final word of a set
//   b_out     active bank, tap k at [k*WIDTH_B +: WIDTH_B], tap 0 nearest x input
//   b_update  1-cycle pulse on the first cycle new b_out is valid
//   busy      high in LOAD, ARMED or DRAIN
//   err_len   1-cycle pulse when a set has the wrong length

module fir_coef_loader
  import fir_coef_loader_pkg::*;
#(
  parameter int WIDTH_B = DEF_WIDTH_B,
  parameter int NTAPS   = DEF_NTAPS,
  localparam int IDX_W  = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH_B-1:0]       s_data,
  input  logic                     s_last,
  output logic [NTAPS*WIDTH_B-1:0] b_out,
  output logic                     b_update,
  output logic                     busy,
  output logic                     err_len
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             b_update_q, b_update_d;
  logic             err_len_q, err_len_d;

  logic             xfer;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             swap;

  assign s_ready = !rst && (state_q != ST_ARMED);
  assign busy    = (state_q != ST_IDLE);
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    b_update_d = 1'b0;
    err_len_d  = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = idx_q;
    swap       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          wr_en  = 1'b1;
          wr_idx = '0;
          if (s_last) begin
            // A one-word set is always short (NTAPS >= 2).
            err_len_d = 1'b1;
            idx_d     = '0;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s_last) begin
              state_d = ST_ARMED;
            end else begin
              // Overlong set: swallow the rest up to its s_last.
              err_len_d = 1'b1;
              state_d   = ST_DRAIN;
            end
          end else if (s_last) begin
            err_len_d = 1'b1;
            idx_d     = '0;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_ARMED: begin
        if (ena) begin
          swap       = 1'b1;
          b_update_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (xfer && s_last) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      b_update_q <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      b_update_q <= b_update_d;
      err_len_q  <= err_len_d;
    end
  end

  assign b_update = b_update_q;
  assign err_len  = err_len_q;

  fir_coef_bank #(
    .WIDTH_B (WIDTH_B),
    .NTAPS   (NTAPS)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .swap    (swap),
    .b_out   (b_out)
  );

endmodule
